// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue
//
// Fetch engine plus an N-entry prefetch queue that sits in front of decode.
// Instruction memory is reached through a req/ack handshake with at most one
// request in flight. Fetched {pc, instruction} pairs leave through a
// valid/ready handshake. A redirect (JAL, JALR, taken branch) flushes the
// queue and restarts fetch at the new target.
//
// Ports:
//   clk          single clock, all state updates on the rising edge
//   reset        asynchronous active-high reset, clears all state at once
//   imem_req     fetch request to instruction memory
//   imem_addr    fetch address, held stable until acknowledged
//   imem_ack     memory response, imem_rdata is valid in this cycle
//   imem_rdata   instruction returned by memory
//   redirect     one-cycle pulse: flush the queue and restart fetch
//   redirect_pc  restart address, low two bits are forced to zero
//   ir_valid     queue head holds a valid instruction
//   ir_instr     instruction at the queue head
//   ir_pc        PC of the instruction at the queue head
//   ir_ready     consumer pops the head when ir_valid and ir_ready are high
//   q_count      current queue occupancy
//   stat_fetched number of instructions pushed into the queue
//   stat_dropped number of memory responses discarded because of a redirect
//
// Optional feature macro: FETCH_STATS_EN
//   Defined   : stat_fetched / stat_dropped are 32-bit wrapping counters.
//   Undefined : no counters are built, both stat ports read as zero.

module instr_fetch_queue #(
  parameter int                ADDR_W   = 32,
  parameter int                INSTR_W  = 32,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  output logic                       imem_req,
  output logic [ADDR_W-1:0]          imem_addr,
  input  logic                       imem_ack,
  input  logic [INSTR_W-1:0]         imem_rdata,
  input  logic                       redirect,
  input  logic [ADDR_W-1:0]          redirect_pc,
  output logic                       ir_valid,
  output logic [INSTR_W-1:0]         ir_instr,
  output logic [ADDR_W-1:0]          ir_pc,
  input  logic                       ir_ready,
  output logic [$clog2(DEPTH):0]     q_count,
  output logic [31:0]                stat_fetched,
  output logic [31:0]                stat_dropped
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [ADDR_W-1:0]  fpc;
  logic               outstanding;
  logic               drop;
  logic [PW-1:0]      rd_ptr;
  logic [PW-1:0]      wr_ptr;
  logic [CW-1:0]      count;
  logic [ADDR_W-1:0]  pc_mem    [DEPTH];
  logic [INSTR_W-1:0] instr_mem [DEPTH];

  logic push;
  logic pop;
  logic drop_ack;
  logic unused_bits;

  // Only word-aligned targets exist, so the low redirect bits carry nothing.
  assign unused_bits = ^redirect_pc[1:0];

  // A live request stays up until acknowledged. A new one is only raised when
  // there is a free slot, so every accepted response is guaranteed a place in
  // the queue. A pending discard or a redirect keeps the request line low.
  assign imem_req  = !reset && !redirect && !drop && (outstanding || (count < DEPTH_C));
  assign imem_addr = fpc;

  // An ack only counts while a request is live; anything else is stray.
  assign push     = imem_req && imem_ack;
  assign drop_ack = outstanding && imem_ack && (drop || redirect);
  assign pop      = ir_valid && ir_ready && !redirect;

  assign ir_valid = (count != '0);
  assign ir_instr = instr_mem[rd_ptr];
  assign ir_pc    = pc_mem[rd_ptr];
  assign q_count  = count;

  // Fetch control and queue bookkeeping. Redirect wins over everything: it
  // empties the queue, retargets fetch and, if a response is still owed,
  // marks it for discard. A single drop flag is enough because only one
  // request can ever be in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fpc         <= RESET_PC;
      outstanding <= 1'b0;
      drop        <= 1'b0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
    end else if (redirect) begin
      fpc    <= {redirect_pc[ADDR_W-1:2], 2'b00};
      count  <= '0;
      rd_ptr <= wr_ptr;
      if (outstanding) begin
        if (imem_ack) begin
          outstanding <= 1'b0;
          drop        <= 1'b0;
        end else begin
          drop <= 1'b1;
        end
      end
    end else begin
      if (push) begin
        wr_ptr      <= wr_ptr + PW'(1);
        fpc         <= fpc + ADDR_W'(4);
        outstanding <= 1'b0;
      end else if (drop_ack) begin
        drop        <= 1'b0;
        outstanding <= 1'b0;
      end else if (imem_req) begin
        outstanding <= 1'b1;
      end

      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end

      // Simultaneous push and pop leave the occupancy unchanged.
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Queue storage. Cleared on reset so the head outputs read zero afterwards.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem[i]    <= '0;
        instr_mem[i] <= '0;
      end
    end else if (push) begin
      pc_mem[wr_ptr]    <= fpc;
      instr_mem[wr_ptr] <= imem_rdata;
    end
  end

`ifdef FETCH_STATS_EN
  // Event counters; they wrap naturally at 2^32.
  logic [31:0] fetched_cnt;
  logic [31:0] dropped_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetched_cnt <= '0;
      dropped_cnt <= '0;
    end else begin
      if (push) begin
        fetched_cnt <= fetched_cnt + 32'd1;
      end
      if (drop_ack) begin
        dropped_cnt <= dropped_cnt + 32'd1;
      end
    end
  end

  assign stat_fetched = fetched_cnt;
  assign stat_dropped = dropped_cnt;
`else
  assign stat_fetched = '0;
  assign stat_dropped = '0;
`endif

endmodule

// File: tb/tb_instr_fetch_queue.sv
// tb_instr_fetch_queue
//
// Directed bench for instr_fetch_queue (DEPTH=4, RESET_PC=0). A small memory
// responder with programmable latency answers fetches with addr^0xA5A5A5A5.
// Every accepted response pushes the expected {pc, instr} pair onto a
// scoreboard queue; the queue head, occupancy, request line and fetch address
// are compared against the DUT every cycle.

module tb_instr_fetch_queue;

  localparam int DEPTH = 4;
  localparam logic [31:0] PATTERN = 32'hA5A5A5A5;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        ir_valid;
  logic [31:0] ir_instr;
  logic [31:0] ir_pc;
  logic        ir_ready;
  logic [2:0]  q_count;
  logic [31:0] stat_fetched;
  logic [31:0] stat_dropped;

  int n_cmp = 0;
  int n_bad = 0;

  exp_t        exp_q[$];
  logic [31:0] exp_fpc;
  logic [31:0] exp_fetched;
  logic [31:0] exp_dropped;
  logic        tb_drop;
  logic        pend;
  logic [31:0] pend_addr;
  int          cnt;
  int          mem_lat;

  instr_fetch_queue #(
    .ADDR_W   (32),
    .INSTR_W  (32),
    .DEPTH    (DEPTH),
    .RESET_PC (32'h0)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .ir_valid     (ir_valid),
    .ir_instr     (ir_instr),
    .ir_pc        (ir_pc),
    .ir_ready     (ir_ready),
    .q_count      (q_count),
    .stat_fetched (stat_fetched),
    .stat_dropped (stat_dropped)
  );

  // Free-running 10-unit clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard time limit so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Checks the stat ports against the bench's own event counts.
  task automatic checkStats();
`ifdef FETCH_STATS_EN
    checkOutput("stat_fetched", 64'(stat_fetched), 64'(exp_fetched));
    checkOutput("stat_dropped", 64'(stat_dropped), 64'(exp_dropped));
`else
    checkOutput("stat_fetched", 64'(stat_fetched), 64'd0);
    checkOutput("stat_dropped", 64'(stat_dropped), 64'd0);
`endif
  endtask

  // Asynchronous reset: checks the outputs clear without a clock edge, keeps
  // a stray ack high across an edge while in reset, then releases just after
  // a rising edge so the first post-reset request is seen by the responder.
  task automatic resetDut();
    reset    = 1'b1;
    imem_ack = 1'b0;
    redirect = 1'b0;
    ir_ready = 1'b0;
    #1;
    checkOutput("rst_imem_req", 64'(imem_req), 64'd0);
    checkOutput("rst_ir_valid", 64'(ir_valid), 64'd0);
    checkOutput("rst_q_count", 64'(q_count), 64'd0);
    checkOutput("rst_ir_instr", 64'(ir_instr), 64'd0);
    checkOutput("rst_ir_pc", 64'(ir_pc), 64'd0);
    exp_q.delete();
    exp_fpc     = 32'h0;
    exp_fetched = 32'h0;
    exp_dropped = 32'h0;
    tb_drop     = 1'b0;
    pend        = 1'b0;
    cnt         = 0;
    checkStats();
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEADBEEF;
    @(posedge clk);
    @(posedge clk);
    #1;
    imem_ack = 1'b0;
    reset    = 1'b0;
  endtask

  // One clock cycle: drive inputs at the falling edge, check the DUT state,
  // run the memory responder and advance the expected model to the next edge.
  task automatic applyStimulus(input logic rdr, input logic [31:0] rpc,
                               input logic rdy, input logic stray);
    logic        exp_req;
    logic        ack_now;
    logic [31:0] ack_addr;
    @(negedge clk);
    redirect    = rdr;
    redirect_pc = rpc;
    ir_ready    = rdy;
    imem_ack    = 1'b0;
    imem_rdata  = 32'h0;
    #1;
    checkOutput("q_count", 64'(q_count), 64'(exp_q.size()));
    checkOutput("ir_valid", 64'(ir_valid), 64'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      checkOutput("ir_pc", 64'(ir_pc), 64'(exp_q[0].pc));
      checkOutput("ir_instr", 64'(ir_instr), 64'(exp_q[0].instr));
    end
    checkStats();
    exp_req = !rdr && !tb_drop && (pend || (exp_q.size() < DEPTH));
    checkOutput("imem_req", 64'(imem_req), 64'(exp_req));
    if (imem_req) begin
      if (pend) begin
        checkOutput("addr_stable", 64'(imem_addr), 64'(pend_addr));
      end else begin
        checkOutput("imem_addr", 64'(imem_addr), 64'(exp_fpc));
        pend      = 1'b1;
        pend_addr = imem_addr;
        cnt       = 0;
      end
    end
    ack_now  = 1'b0;
    ack_addr = 32'h0;
    if (pend) begin
      if (cnt == mem_lat) begin
        ack_now    = 1'b1;
        ack_addr   = pend_addr;
        pend       = 1'b0;
        imem_ack   = 1'b1;
        imem_rdata = pend_addr ^ PATTERN;
      end else begin
        cnt++;
      end
    end else if (stray) begin
      imem_ack   = 1'b1;
      imem_rdata = 32'hDEADBEEF;
    end
    if (rdr) begin
      exp_q.delete();
      exp_fpc = rpc & 32'hFFFFFFFC;
    end else if (rdy && exp_q.size() != 0) begin
      void'(exp_q.pop_front());
    end
    if (ack_now) begin
      if (rdr || tb_drop) begin
        exp_dropped = exp_dropped + 32'd1;
        tb_drop     = 1'b0;
      end else begin
        exp_q.push_back('{ack_addr, ack_addr ^ PATTERN});
        exp_fetched = exp_fetched + 32'd1;
        exp_fpc     = ack_addr + 32'd4;
      end
    end else if (rdr && pend) begin
      tb_drop = 1'b1;
    end
  endtask

  initial begin
    reset       = 1'b1;
    imem_ack    = 1'b0;
    imem_rdata  = 32'h0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    ir_ready    = 1'b0;
    mem_lat     = 0;
    pend        = 1'b0;
    cnt         = 0;

    // Zero-wait memory streaming at one fetch per cycle
    $display("[TB] streaming with zero-wait memory");
    resetDut();
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);

    // Stall the consumer until the queue fills, then a stray ack and one pop
    $display("[TB] fill queue with consumer stalled");
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);

    // Slow memory, redirect while the fetch of 0x8 is still in flight
    $display("[TB] redirect with a slow response outstanding");
    resetDut();
    mem_lat = 3;
    for (int i = 0; i < 40 && !(pend && pend_addr == 32'h8); i++)
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    checkOutput("reach_fetch_8", 64'(pend && pend_addr == 32'h8), 64'd1);
    applyStimulus(1'b1, 32'h103, 1'b0, 1'b0);
    for (int i = 0; i < 14; i++) applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);

    // Redirect coinciding with an ack and a pop while two entries are queued
    $display("[TB] redirect together with ack and pop");
    resetDut();
    mem_lat = 1;
    for (int i = 0; i < 40 && !(exp_q.size() == 2 && pend && cnt == mem_lat); i++)
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    checkOutput("reach_two_queued", 64'(exp_q.size() == 2 && pend && cnt == mem_lat), 64'd1);
    applyStimulus(1'b1, 32'h200, 1'b1, 1'b0);
    mem_lat = 0;
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);

    // Fetch address wraps past the top of the address space
    $display("[TB] fetch address wrap");
    applyStimulus(1'b1, 32'hFFFFFFFC, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);

    // Reset while a request is up and three entries are queued
    $display("[TB] reset mid-transaction");
    resetDut();
    for (int i = 0; i < 20 && exp_q.size() != 3; i++)
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    checkOutput("pre_rst_q_count", 64'(q_count), 64'd3);
    checkOutput("pre_rst_imem_req", 64'(imem_req), 64'd1);
    resetDut();
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
